// File: rtl/llr_frame_buffer.sv
// rtl/llr_frame_buffer.sv - ping-pong LLR frame buffer feeding the interleaver
// One bank fills from the input stream while the other drains in natural order.
module llr_frame_buffer #(
    parameter int unsigned FRAME_LEN = 40,
    parameter int unsigned DATA_W    = 16
) (
    input  logic              clk_p_i,
    input  logic              reset_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_sof_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_sof_o,
    output logic              out_eof_o,
    output logic              sync_err_o
);

    localparam int unsigned      CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]       full_q, full_d;
    logic             sync_err_q, sync_err_d;

    logic [DATA_W-1:0] mem_q [2][FRAME_LEN];

    logic             in_fire;
    logic             out_fire;
    logic             sof_restart;
    logic [CNT_W-1:0] wr_addr;

    assign in_ready_o  = !full_q[wr_bank_q];
    assign out_valid_o = full_q[rd_bank_q];
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = out_valid_o && out_ready_i;
    assign sof_restart = in_fire && in_sof_i && (wr_cnt_q != '0);
    assign wr_addr     = sof_restart ? '0 : wr_cnt_q;

    assign out_data_o  = out_valid_o ? mem_q[rd_bank_q][rd_cnt_q] : '0;
    assign out_sof_o   = out_valid_o && (rd_cnt_q == '0);
    assign out_eof_o   = out_valid_o && (rd_cnt_q == LAST_IDX);
    assign sync_err_o  = sync_err_q;

    always_comb begin
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        full_d     = full_q;
        sync_err_d = 1'b0;

        // A mid-frame SOF restarts the frame, even when it lands on the last index
        if (in_fire) begin
            if (sof_restart) begin
                wr_cnt_d   = CNT_W'(1);
                sync_err_d = 1'b1;
            end else if (wr_cnt_q == LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_cnt_d          = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
        end

        // Set and clear always hit different banks, so both may apply together
        if (out_fire) begin
            if (rd_cnt_q == LAST_IDX) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
                rd_cnt_d          = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            full_q     <= 2'b00;
            sync_err_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            full_q     <= full_d;
            sync_err_q <= sync_err_d;
        end
    end

    always_ff @(posedge clk_p_i) begin
        if (in_fire) begin
            mem_q[wr_bank_q][wr_addr] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_llr_frame_buffer.sv
// tb/tb_llr_frame_buffer.sv - bench for llr_frame_buffer
module tb_llr_frame_buffer;

    localparam int FL = 40;
    localparam int DW = 16;

    logic          clk_p_i = 1'b0;
    logic          reset_n_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic          in_sof_i;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic          out_sof_o;
    logic          out_eof_o;
    logic          sync_err_o;

    llr_frame_buffer #(.FRAME_LEN(FL), .DATA_W(DW)) dut (
        .clk_p_i     (clk_p_i),
        .reset_n_i   (reset_n_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_sof_i    (in_sof_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_sof_o   (out_sof_o),
        .out_eof_o   (out_eof_o),
        .sync_err_o  (sync_err_o)
    );

    initial forever #5 clk_p_i = ~clk_p_i;

    typedef struct {
        int nframes;
        int err_at;
        int vpct;
        int rpct;
        int hold;
        int hold_acc;
        bit seq;
        bit nosof;
        bit nobubble;
        int exp_frames;
        int exp_errs;
    } scn_t;

    scn_t scn [7];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: frames are assembled from accepted words with a plain queue
    logic [DW-1:0] part_q[$];
    logic [DW-1:0] exp_q[$];
    int            buffered   = 0;
    int            out_idx    = 0;
    bit            err_exp    = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data  = '0;
    int            obs_frames = 0;
    int            obs_errs   = 0;
    bit            mon_acc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic monitor();
        mon_acc = 0;
        if (!reset_n_i) begin
            part_q.delete();
            exp_q.delete();
            buffered   = 0;
            out_idx    = 0;
            err_exp    = 0;
            prev_stall = 0;
            return;
        end
        chk("in_ready", int'(in_ready_o), int'(buffered < 2));
        chk("out_valid", int'(out_valid_o), int'(buffered > 0));
        chk("sync_err", int'(sync_err_o), int'(err_exp));
        if (sync_err_o) obs_errs++;
        if (buffered > 0 && exp_q.size() > 0) begin
            chk("out_data", int'(out_data_o), int'(exp_q[0]));
            chk("out_sof", int'(out_sof_o), int'((out_idx % FL) == 0));
            chk("out_eof", int'(out_eof_o), int'((out_idx % FL) == FL - 1));
        end else begin
            chk("idle_data", int'(out_data_o), 0);
            chk("idle_sof", int'(out_sof_o), 0);
            chk("idle_eof", int'(out_eof_o), 0);
        end
        if (prev_stall) chk("stall_hold", int'(out_data_o), int'(prev_data));
        prev_stall = out_valid_o && !out_ready_i;
        prev_data  = out_data_o;
        err_exp    = 0;
        if (out_valid_o && out_ready_i) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if ((out_idx % FL) == FL - 1) begin
                if (buffered > 0) buffered--;
                obs_frames++;
            end
            out_idx++;
        end
        if (in_valid_i && in_ready_o) begin
            mon_acc = 1;
            if (in_sof_i && part_q.size() > 0) begin
                part_q.delete();
                err_exp = 1;
            end
            part_q.push_back(in_data_i);
            if (part_q.size() == FL) begin
                foreach (part_q[i]) exp_q.push_back(part_q[i]);
                part_q.delete();
                buffered++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_p_i);
        monitor();
        @(posedge clk_p_i);
        #1;
    endtask

    task automatic run_scn(input int k);
        scn_t          s;
        logic [DW-1:0] words[$];
        bit            sofs[$];
        int            n, idx, frames0, errs0, bubbles, install;
        bit            done, started;
        s = scn[k];
        for (int i = 0; i < s.err_at; i++) begin
            words.push_back(DW'($urandom));
            sofs.push_back(i == 0);
        end
        for (int f = 0; f < s.nframes; f++) begin
            for (int i = 0; i < FL; i++) begin
                words.push_back(s.seq ? DW'(f * FL + i) : DW'($urandom));
                sofs.push_back(!s.nosof && i == 0);
            end
        end
        n = words.size();
        idx = 0; done = 0; started = 0; bubbles = 0; install = 0;
        frames0 = obs_frames;
        errs0   = obs_errs;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            if (idx < n) begin
                in_valid_i = ($urandom_range(99) < s.vpct);
                in_data_i  = words[idx];
                in_sof_i   = sofs[idx];
            end else begin
                in_valid_i = 1'b0;
                in_sof_i   = 1'b0;
            end
            out_ready_i = (cyc < s.hold) ? 1'b0 : ($urandom_range(99) < s.rpct);
            tick();
            if (mon_acc) idx++;
            if (s.hold > 0 && cyc + 1 == s.hold) begin
                chk($sformatf("s%0d_hold_accepts", k), idx, s.hold_acc);
                chk($sformatf("s%0d_hold_in_ready", k), int'(in_ready_o), 0);
            end
            if (out_valid_o) started = 1;
            if (s.nobubble && started && (obs_frames - frames0) < s.exp_frames && !out_valid_o)
                bubbles++;
            if (s.nobubble && idx < n && !in_ready_o) install++;
            if (idx >= n && buffered == 0) done = 1;
        end
        chk($sformatf("s%0d_timeout", k), int'(done), 1);
        in_valid_i  = 1'b0;
        in_sof_i    = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) tick();
        chk($sformatf("s%0d_frames", k), obs_frames - frames0, s.exp_frames);
        chk($sformatf("s%0d_sync_errs", k), obs_errs - errs0, s.exp_errs);
        chk($sformatf("s%0d_drained", k), int'(out_valid_o), 0);
        if (s.nobubble) begin
            chk($sformatf("s%0d_out_bubbles", k), bubbles, 0);
            chk($sformatf("s%0d_in_stalls", k), install, 0);
        end
    endtask

    initial begin
        int idx;
        //          nfr err  vp   rp  hold hacc seq   nosof nobub fr err
        scn[0] = '{1,  -1, 100, 100, 0,   0,  1'b1, 1'b0, 1'b0, 1, 0};
        scn[1] = '{3,  -1, 100, 100, 150, 80, 1'b1, 1'b0, 1'b0, 3, 0};
        scn[2] = '{1,  17, 100, 100, 0,   0,  1'b0, 1'b0, 1'b0, 1, 1};
        scn[3] = '{10, -1, 100, 50,  0,   0,  1'b0, 1'b0, 1'b0, 10, 0};
        scn[4] = '{4,  -1, 100, 100, 0,   0,  1'b0, 1'b0, 1'b1, 4, 0};
        scn[5] = '{3,  -1, 60,  70,  0,   0,  1'b0, 1'b1, 1'b0, 3, 0};
        scn[6] = '{1,  39, 100, 100, 0,   0,  1'b0, 1'b0, 1'b0, 1, 1};

        reset_n_i   = 1'b0;
        in_valid_i  = 1'b0;
        in_sof_i    = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        repeat (3) @(posedge clk_p_i);
        #1;
        reset_n_i = 1'b1;
        tick();
        chk("rst_in_ready", int'(in_ready_o), 1);
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_out_data", int'(out_data_o), 0);
        chk("rst_sync_err", int'(sync_err_o), 0);

        // Fill one frame plus a partial with the output stalled, then reset mid-frame
        idx = 0;
        for (int cyc = 0; cyc < 200 && idx < 50; cyc++) begin
            in_valid_i = 1'b1;
            in_data_i  = DW'(16'h1000 + idx);
            in_sof_i   = (idx % FL) == 0;
            tick();
            if (mon_acc) idx++;
        end
        chk("pre_reset_accepts", idx, 50);
        chk("pre_reset_out_valid", int'(out_valid_o), 1);
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_in_ready", int'(in_ready_o), 1);
        chk("mid_rst_out_valid", int'(out_valid_o), 0);
        chk("mid_rst_out_data", int'(out_data_o), 0);
        chk("mid_rst_out_sof", int'(out_sof_o), 0);
        chk("mid_rst_sync_err", int'(sync_err_o), 0);
        in_valid_i = 1'b0;
        in_sof_i   = 1'b0;
        tick();
        tick();
        reset_n_i = 1'b1;
        tick();

        for (int k = 0; k < 7; k++) run_scn(k);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/llr_frame_buffer.md
# llr_frame_buffer

Double-buffered (ping-pong) frame buffer directly upstream of the interleaver in the turbo decoder datapath. It collects a stream of 16-bit soft symbols (LLRs) into frames of FRAME_LEN words, then streams each complete frame out in natural order toward the interleaver. While one bank drains, the other bank fills. It also checks input framing: a start-of-frame marker arriving mid-frame discards the partial frame and raises an error pulse.

## Interface

- FRAME_LEN, 40, words per frame; legal range 2..6144.
- DATA_W, 16, LLR word width; the interleaver consumes 16 bits.
- clk_p_i  input  1  clock; all logic is on the rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- in_valid_i  input  1  input word valid.
- in_ready_o  output  1  buffer can accept a word this cycle.
- in_sof_i  input  1  marks the first word of a frame; qualified by in_valid_i.
- in_data_i  input  DATA_W  input LLR.
- out_valid_o  output  1  output word valid.
- out_ready_i  input  1  downstream accepts a word this cycle.
- out_data_o  output  DATA_W  output LLR, natural order.
- out_sof_o  output  1  output word is index 0 of its frame.
- out_eof_o  output  1  output word is index FRAME_LEN-1 of its frame.
- sync_err_o  output  1  one-cycle pulse on a framing error.

## Operation

**Storage and state**
- Storage is two banks of FRAME_LEN x DATA_W registers. Memory contents are not reset.
- State registers: wr_bank, rd_bank (1 bit each); wr_cnt, rd_cnt ($clog2(FRAME_LEN) bits each); full[1:0]; sync_err_o.
- Reset values: wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, full=00, sync_err_o=0.
- Resulting outputs after reset: in_ready_o=1, out_valid_o=0, out_data_o=0, out_sof_o=0, out_eof_o=0.

**Write side**
- in_ready_o = !full[wr_bank].
- An accepted word is in_valid_i && in_ready_o.
- On accept with in_sof_i=1 and wr_cnt!=0:
  - Drop the partial frame.
  - Write the word at index 0 and set wr_cnt=1.
  - Pulse sync_err_o for one cycle.
- On accept with in_sof_i=0 and wr_cnt==0: store the word normally. No error is flagged; a missing SOF is tolerated.
- Otherwise, store at index wr_cnt and increment wr_cnt.
- When the accepted word lands at index FRAME_LEN-1:
  - Set full[wr_bank].
  - Toggle wr_bank.
  - Set wr_cnt=0.
- Case FRAME_LEN-1 combined with an SOF error: the SOF handling wins and the frame restarts.

**Read side**
- out_valid_o = full[rd_bank].
- out_data_o = bank[rd_bank][rd_cnt] while out_valid_o=1, else 0.
- out_sof_o = out_valid_o && rd_cnt==0.
- out_eof_o = out_valid_o && rd_cnt==FRAME_LEN-1.
- On out_valid_o && out_ready_i, increment rd_cnt.
- At the last index:
  - Clear full[rd_bank].
  - Toggle rd_bank.
  - Set rd_cnt=0.
- A word is never skipped or repeated. out_data_o is held stable while out_valid_o=1 && out_ready_i=0.

**Simultaneous events**
- A set and a clear of full[] in the same cycle always target different banks, because a bank being written is never full and a bank being read is always full. Both updates take effect.
- Both banks full: in_ready_o=0 and the input stalls. in_valid_i is ignored.
- Reset mid-frame discards all buffered data.

## Timing

- Write latency: the last word of a frame is accepted in cycle N; the first output word (out_valid_o=1, out_sof_o=1) appears in cycle N+1.
- Throughput: one word in and one word out per cycle, sustained. The buffer never throttles when out_ready_i is held at 1.
- in_ready_o and out_valid_o are combinational from registers only. There are no combinational paths from inputs to outputs.
- sync_err_o is registered. It is high in the cycle after the offending accept.

## Test plan

1. **Reset.** Assert reset_n_i low mid-stream, then release.
   - Required: in_ready_o=1, out_valid_o=0, out_data_o=0, sync_err_o=0.
   - The next frame starts at index 0.
2. **Single frame.** Use FRAME_LEN=40, out_ready_i=1, and write words 0..39.
   - Required: outputs 0..39 in order.
   - out_sof_o appears on value 0, out_eof_o on value 39.
   - The first output appears one cycle after the 40th accept.
3. **Ping-pong back-pressure.** Hold out_ready_i=0 and stream 3 frames.
   - Required: in_ready_o drops to 0 after 80 accepts.
   - Then release out_ready_i. Frame 3 is accepted once bank 0 has drained, and all 120 words emerge in order.
4. **Sync error.** Send in_sof_i at word 0, then again at word 17.
   - Required: sync_err_o pulses once.
   - The frame delivered downstream is the 40 words starting at the second SOF.
5. **Output stall.** Toggle out_ready_i randomly with continuous input.
   - Required: out_data_o is stable during stalls.
   - No loss or duplication occurs across 10 frames, checked against a scoreboard.
6. **Simultaneous fill/drain.** Complete a frame write in the same cycle as the final read of the other bank.
   - Required: both full[] updates apply, and streaming continues with no bubble.
